// File: rtl/pwm_capture.sv
// PWM input capture: measures the period and the high time of an asynchronous PWM input.
// It publishes one result per completed period and flags an input that stops toggling.
module pwm_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW, STUCK} state_e;

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_MAX     = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s, rise, fall, timeout;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign timeout = (cnt_q >= TIMEOUT_CNT);

  // The synchroniser keeps running while disabled, so re-enabling with the
  // input already high does not fabricate a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns this chain into a shift register.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q  <= s;
    end
  end

  always_comb begin
    // NOTE: every variable receives a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    cnt_d         = (state_q != WAIT_RISE && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    hcnt_d        = hcnt_q;
    period_d      = period_q;
    high_d        = high_q;
    valid_d       = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    if (!enable) begin
      state_d = WAIT_RISE;
      cnt_d   = '0;
      hcnt_d  = '0;
      stuck_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = WIDTH'(1);
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            hcnt_d  = cnt_q;
          end else if (timeout) begin
            state_d       = STUCK;
            stuck_d       = 1'b1;
            stuck_level_d = s;
          end
        end
        LOW: begin
          // A rise coinciding with the timeout still closes a valid period.
          if (rise) begin
            state_d  = HIGH;
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            cnt_d    = WIDTH'(1);
          end else if (timeout) begin
            state_d       = STUCK;
            stuck_d       = 1'b1;
            stuck_level_d = s;
          end
        end
        STUCK: begin
          if (rise) begin
            state_d = HIGH;
            stuck_d = 1'b0;
            cnt_d   = WIDTH'(1);
          end else if (fall) begin
            state_d = WAIT_RISE;
            stuck_d = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= WAIT_RISE;
      cnt_q         <= '0;
      hcnt_q        <= '0;
      period_q      <= '0;
      high_q        <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hcnt_q        <= hcnt_d;
      period_q      <= period_d;
      high_q        <= high_d;
      valid_q       <= valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign period_out  = period_q;
  assign high_out    = high_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule
